ocram_stream_dma: RTL

OCRAM_STREAM_DMA -- requirements
Module: ocram_stream_dma

---
 rtl/ocram_stream_dma_if.sv | 53 +++++
 rtl/ocram_stream_dma.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ocram_stream_dma_if.sv
// Bus bundle for ocram_stream_dma: CSR slave port, on-chip RAM master port,
// stream sink/source and interrupt. "slave" is the DMA side, "master" the system side.
interface ocram_stream_dma_if #(
    parameter int ADDR_W = 12
) ();
    logic [1:0]        csr_address;
    logic              csr_write;
    logic              csr_read;
    logic [31:0]       csr_writedata;
    logic [31:0]       csr_readdata;

    logic [ADDR_W-1:0] ram_address;
    logic [3:0]        ram_byteenable;
    logic              ram_chipselect;
    logic              ram_write;
    logic [31:0]       ram_writedata;
    logic              ram_clken;
    logic [31:0]       ram_readdata;

    logic [31:0]       snk_data;
    logic              snk_valid;
    logic              snk_ready;

    logic [31:0]       src_data;
    logic              src_valid;
    logic              src_ready;

    logic              irq;

    modport slave (
        input  csr_address, csr_write, csr_read, csr_writedata,
        output csr_readdata,
        output ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata, ram_clken,
        input  ram_readdata,
        input  snk_data, snk_valid,
        output snk_ready,
        output src_data, src_valid,
        input  src_ready,
        output irq
    );

    modport master (
        output csr_address, csr_write, csr_read, csr_writedata,
        input  csr_readdata,
        input  ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata, ram_clken,
        output ram_readdata,
        output snk_data, snk_valid,
        input  snk_ready,
        input  src_data, src_valid,
        output src_ready,
        input  irq
    );
endinterface

// File: rtl/ocram_stream_dma.sv
// Single-channel DMA between a 32-bit stream and an on-chip RAM: sink->RAM writes
// one word per accepted beat; RAM->source reads through a 2-entry FIFO at one word/clk.
module ocram_stream_dma #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 3840
) (
    input  logic              clk,
    input  logic              reset_n,
    ocram_stream_dma_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_DONE} state_t;

    localparam logic [13:0] DEPTH_L = 14'(DEPTH);

    state_t            state_q;
    logic [1:0]        rst_sync_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [12:0]       len_q;
    logic [12:0]       cnt_q;
    logic              dir_q, irq_en_q;
    logic              done_q, err_q, aborted_q;
    logic              done_d, err_d, aborted_d;
    logic [31:0]       rdata_q;
    logic [31:0]       fifo_q [2];
    logic              wr_idx_q, rd_idx_q, inflight_q;
    logic [1:0]        occ_q;

    logic              ctrl_wr, start_req, abort_req, abort_act, busy, range_bad, run_ok;
    logic              wr_beat, rd_issue, pop, push;
    logic [2:0]        occ_net;
    logic [2:0]        w1c;
    logic [31:0]       rd_mux;
    logic              unused_bits;

    assign unused_bits = &{1'b0, bus.csr_writedata[31:13]};

    always_comb begin
        ctrl_wr   = bus.csr_write && (bus.csr_address == 2'd0);
        // abort takes priority over a start written in the same cycle
        start_req = ctrl_wr && bus.csr_writedata[0] && !bus.csr_writedata[3];
        abort_req = ctrl_wr && bus.csr_writedata[3];
        busy      = (state_q != S_IDLE);
        abort_act = abort_req && (state_q == S_WR || state_q == S_RD || state_q == S_DRAIN);
        run_ok    = rst_sync_q[1];
        // sum widened past 13 bits so a large BASE+LEN cannot wrap into range
        range_bad = (len_q == 13'd0) || ((14'(base_q) + 14'(len_q)) > DEPTH_L);

        wr_beat   = (state_q == S_WR) && !abort_req && bus.snk_valid;
        pop       = (occ_q != 2'd0) && bus.src_ready;
        push      = inflight_q;
        occ_net   = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
        rd_issue  = (state_q == S_RD) && !abort_req && (cnt_q != 13'd0) && (occ_net < 3'd2);

        w1c       = (bus.csr_write && bus.csr_address == 2'd3) ? bus.csr_writedata[3:1] : 3'b000;
        done_d    = (done_q & ~w1c[0]) | (state_q == S_DONE);
        err_d     = (err_q & ~w1c[1]) | ((state_q == S_IDLE) && start_req && run_ok && range_bad);
        aborted_d = (aborted_q & ~w1c[2]) | abort_act;

        rd_mux = '0;
        case (bus.csr_address)
            2'd0:    rd_mux = {29'd0, irq_en_q, dir_q, 1'b0};
            2'd1:    rd_mux = 32'(base_q);
            2'd2:    rd_mux = {19'd0, len_q};
            default: rd_mux = {28'd0, aborted_q, err_q, done_q, busy};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            rst_sync_q <= '0;
            base_q     <= '0;
            ptr_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            aborted_q  <= 1'b0;
            rdata_q    <= '0;
            for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
            wr_idx_q   <= 1'b0;
            rd_idx_q   <= 1'b0;
            inflight_q <= 1'b0;
            occ_q      <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
            rdata_q    <= bus.csr_read ? rd_mux : 32'd0;
            done_q     <= done_d;
            err_q      <= err_d;
            aborted_q  <= aborted_d;

            if (!busy && bus.csr_write) begin
                case (bus.csr_address)
                    2'd0: begin
                        dir_q    <= bus.csr_writedata[1];
                        irq_en_q <= bus.csr_writedata[2];
                    end
                    2'd1:    base_q <= bus.csr_writedata[ADDR_W-1:0];
                    2'd2:    len_q  <= bus.csr_writedata[12:0];
                    default: ;
                endcase
            end

            if (abort_act) begin
                occ_q      <= '0;
                inflight_q <= 1'b0;
                wr_idx_q   <= 1'b0;
                rd_idx_q   <= 1'b0;
            end else begin
                inflight_q <= rd_issue;
                if (push) begin
                    fifo_q[wr_idx_q] <= bus.ram_readdata;
                    wr_idx_q         <= ~wr_idx_q;
                end
                if (pop) rd_idx_q <= ~rd_idx_q;
                occ_q <= occ_q + 2'(push) - 2'(pop);
            end

            if (wr_beat || rd_issue) ptr_q <= ptr_q + ADDR_W'(1);

            case (state_q)
                S_IDLE: begin
                    if (start_req && run_ok && !range_bad) begin
                        state_q <= bus.csr_writedata[1] ? S_RD : S_WR;
                        ptr_q   <= base_q;
                        cnt_q   <= len_q;
                    end
                end
                S_WR: begin
                    if (abort_req) begin
                        state_q <= S_IDLE;
                    end else if (wr_beat) begin
                        cnt_q <= cnt_q - 13'd1;
                        if (cnt_q == 13'd1) state_q <= S_DONE;
                    end
                end
                S_RD: begin
                    if (abort_req) begin
                        state_q <= S_IDLE;
                    end else if (rd_issue) begin
                        cnt_q <= cnt_q - 13'd1;
                        if (cnt_q == 13'd1) state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (abort_req) state_q <= S_IDLE;
                    else if (occ_q == 2'd0 && !inflight_q) state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.csr_readdata   = rdata_q;
    assign bus.snk_ready      = (state_q == S_WR) && !abort_req;
    assign bus.ram_clken      = 1'b1;
    assign bus.ram_chipselect = wr_beat || rd_issue;
    assign bus.ram_write      = wr_beat;
    assign bus.ram_byteenable = (wr_beat || rd_issue) ? 4'hF : 4'h0;
    assign bus.ram_address    = (wr_beat || rd_issue) ? ptr_q : '0;
    assign bus.ram_writedata  = wr_beat ? bus.snk_data : 32'd0;
    assign bus.src_valid      = (occ_q != 2'd0);
    assign bus.src_data       = fifo_q[rd_idx_q];
    assign bus.irq            = irq_en_q & (done_q | err_q | aborted_q);
endmodule
